// File: rtl/uart_rx_sched_pkg.sv
// Shared definitions for the uart_rx scheduler slice.
//  - ch_state_e : per-channel receiver control state (OFF / ACTIVE / REARM)
//  - DATA_W     : byte width delivered by each uart_rx
//  - wrap_idx() : round-robin index helper used by the arbiter
package uart_rx_sched_pkg;

  typedef enum logic [1:0] {
    CH_OFF    = 2'd0,
    CH_ACTIVE = 2'd1,
    CH_REARM  = 2'd2
  } ch_state_e;

  localparam int unsigned DATA_W = 8;

  // Channel index `off` positions after `base`, wrapping modulo n.
  function automatic int unsigned wrap_idx(int unsigned base, int unsigned off,
                                           int unsigned n);
    return (base + off) % n;
  endfunction

endpackage

// File: rtl/uart_rx_sched_if.sv
// Merged byte stream between the scheduler and the host-side consumer.
//  m_valid : byte available at the FIFO head
//  m_ready : consumer accepts on m_valid & m_ready
//  m_data  : byte at the FIFO head
//  m_ch    : source channel of m_data
// master = scheduler (producer), slave = consumer.
interface uart_rx_sched_if #(
  parameter int NUM_CH = 4
) ();
  localparam int CH_W = $clog2(NUM_CH);

  logic            m_valid;
  logic            m_ready;
  logic [7:0]      m_data;
  logic [CH_W-1:0] m_ch;

  modport master (output m_valid, m_data, m_ch, input m_ready);
  modport slave  (input m_valid, m_data, m_ch, output m_ready);
endinterface

// File: rtl/uart_rx_fifo.sv
// Synchronous FIFO with a registered head entry.
//  clk, rst_n : clock, asynchronous active-low reset
//  push/wdata : write request (ignored while full)
//  pop        : read request (ignored while empty)
//  rdata      : registered head entry; holds when nothing is popped
//  empty      : registered, no entries held
//  count      : number of entries, $clog2(DEPTH)+1 bits
// A push into an empty FIFO is visible at rdata right after the write edge.
// A pop from a full FIFO frees a slot for the following cycle only.
module uart_rx_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr, rd_ptr_nxt;
  logic [CW-1:0]    count_nxt, remain;
  logic             full, do_push, do_pop;

  assign full       = (count == CW'(DEPTH));
  assign do_push    = push && !full;
  assign do_pop     = pop && !empty;
  assign rd_ptr_nxt = rd_ptr + AW'(do_pop);
  assign remain     = count - CW'(do_pop);
  assign count_nxt  = remain + CW'(do_push);

  // NOTE: storage array has no reset; only pointers, count and the head
  // register need a known value, and leaving the array out lets it map to RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      empty  <= 1'b1;
      rdata  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(do_push);
      rd_ptr <= rd_ptr_nxt;
      count  <= count_nxt;
      empty  <= (count_nxt == '0);
      // Head after this edge: an older entry if one remains, otherwise the
      // entry being written now; with neither, the last value holds.
      if (remain != '0) rdata <= mem[rd_ptr_nxt];
      else if (do_push) rdata <= wdata;
    end
  end

endmodule

// File: rtl/uart_rx_sched.sv
// uart_rx_sched: controls NUM_CH uart_rx receivers and merges their bytes.
//  clk, rst_n : clock (shared with the uart_rx bank), async active-low reset
//  cfg_ch_en  : per-channel enable request (level)
//  ovr_clr    : per-channel pulse, clears the sticky overrun flag
//  rx_en      : registered enable to each uart_rx (1 only in ACTIVE)
//  rx_data    : uart_rx bytes, channel i at [8i+7:8i]
//  rx_done    : uart_rx byte-done pulses
//  rx_err     : uart_rx framing error levels
//  m_bus      : merged valid/ready byte stream (uart_rx_sched_if.master)
//  ovr        : sticky, a byte was dropped because its capture slot was full
//  fifo_full  : merged FIFO holds FIFO_DEPTH entries
// Optional build macro UART_RX_SCHED_STATS_EN adds stat_sel / stat_frames /
// stat_errs: per-channel saturating counts of pushed bytes and error rearms,
// read through a registered mux with one clock of latency.
module uart_rx_sched
  import uart_rx_sched_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int FIFO_DEPTH   = 8,
  parameter int REARM_CYCLES = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_CH-1:0]         cfg_ch_en,
  input  logic [NUM_CH-1:0]         ovr_clr,
  output logic [NUM_CH-1:0]         rx_en,
  input  logic [8*NUM_CH-1:0]       rx_data,
  input  logic [NUM_CH-1:0]         rx_done,
  input  logic [NUM_CH-1:0]         rx_err,
  uart_rx_sched_if.master           m_bus,
  output logic [NUM_CH-1:0]         ovr,
  output logic                      fifo_full
`ifdef UART_RX_SCHED_STATS_EN
  ,
  input  logic [$clog2(NUM_CH)-1:0] stat_sel,
  output logic [7:0]                stat_frames,
  output logic [7:0]                stat_errs
`endif
);
  localparam int CH_W    = $clog2(NUM_CH);
  localparam int ENTRY_W = DATA_W + CH_W;
  localparam int RW      = $clog2(REARM_CYCLES + 1);
  localparam int CW      = $clog2(FIFO_DEPTH) + 1;

  // ---------------- per-channel control FSM ----------------
  ch_state_e       state_q [NUM_CH];
  ch_state_e       state_d [NUM_CH];
  logic [RW-1:0]   rearm_q [NUM_CH];
  logic [RW-1:0]   rearm_d [NUM_CH];

  // NOTE: every variable gets its default before the case so no path leaves
  // it unassigned (which would infer a latch); blocking '=' is correct here
  // because this block is combinational.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i] = state_q[i];
      rearm_d[i] = rearm_q[i];
      if (!cfg_ch_en[i]) begin
        state_d[i] = CH_OFF;
      end else begin
        unique case (state_q[i])
          CH_OFF:    state_d[i] = CH_ACTIVE;
          CH_ACTIVE: begin
            if (rx_err[i]) begin
              state_d[i] = CH_REARM;
              rearm_d[i] = RW'(REARM_CYCLES - 1);
            end
          end
          CH_REARM: begin
            if (rearm_q[i] == '0) state_d[i] = CH_ACTIVE;
            else                  rearm_d[i] = rearm_q[i] - 1'b1;
          end
          default:   state_d[i] = CH_OFF;
        endcase
      end
    end
  end

  // NOTE: sequential state uses non-blocking '<=' so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= CH_OFF;
        rearm_q[i] <= '0;
      end
      rx_en <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= state_d[i];
        rearm_q[i] <= rearm_d[i];
        rx_en[i]   <= (state_d[i] == CH_ACTIVE);
      end
    end
  end

  // ---------------- capture slots and round-robin arbiter ----------------
  logic [NUM_CH-1:0] slot_valid_q;
  logic [7:0]        slot_data_q [NUM_CH];
  logic [CH_W-1:0]   rr_q;
  logic              grant_valid;
  logic [CH_W-1:0]   grant_ch;
  int unsigned       idx;

  // First pending slot after the pointer, decided on cycle-start state only.
  always_comb begin
    grant_valid = 1'b0;
    grant_ch    = '0;
    idx         = 0;
    if (!fifo_full) begin
      for (int off = 1; off <= NUM_CH; off++) begin
        idx = wrap_idx(int'(rr_q), off, NUM_CH);
        if (!grant_valid && slot_valid_q[idx]) begin
          grant_valid = 1'b1;
          grant_ch    = CH_W'(idx);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_valid_q <= '0;
      ovr          <= '0;
      rr_q         <= CH_W'(NUM_CH - 1);
      for (int i = 0; i < NUM_CH; i++) slot_data_q[i] <= '0;
    end else begin
      if (grant_valid) rr_q <= grant_ch;
      for (int i = 0; i < NUM_CH; i++) begin
        if (ovr_clr[i]) ovr[i] <= 1'b0;
        if (grant_valid && grant_ch == CH_W'(i)) slot_valid_q[i] <= 1'b0;
        // Occupancy is judged at cycle start: a slot granted this cycle still
        // counts as occupied, and the overrun set overrides a same-cycle clear.
        if (state_q[i] == CH_ACTIVE && rx_done[i]) begin
          if (slot_valid_q[i]) begin
            ovr[i] <= 1'b1;
          end else begin
            slot_valid_q[i] <= 1'b1;
            slot_data_q[i]  <= rx_data[8*i +: 8];
          end
        end
      end
    end
  end

  // ---------------- merged FIFO ----------------
  logic [ENTRY_W-1:0] head;
  logic               fifo_empty;
  logic [CW-1:0]      fifo_count;

  uart_rx_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (grant_valid),
    .wdata ({grant_ch, slot_data_q[grant_ch]}),
    .pop   (m_bus.m_valid && m_bus.m_ready),
    .rdata (head),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign m_bus.m_valid = !fifo_empty;
  assign m_bus.m_data  = head[7:0];
  assign m_bus.m_ch    = head[ENTRY_W-1:8];
  assign fifo_full     = (fifo_count == CW'(FIFO_DEPTH));

`ifdef UART_RX_SCHED_STATS_EN
  // ---------------- optional statistics ----------------
  logic [7:0] frames_q [NUM_CH];
  logic [7:0] errs_q   [NUM_CH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        frames_q[i] <= '0;
        errs_q[i]   <= '0;
      end
      stat_frames <= '0;
      stat_errs   <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (grant_valid && grant_ch == CH_W'(i) && frames_q[i] != 8'hFF)
          frames_q[i] <= frames_q[i] + 8'd1;
        if (state_q[i] == CH_ACTIVE && state_d[i] == CH_REARM && errs_q[i] != 8'hFF)
          errs_q[i] <= errs_q[i] + 8'd1;
      end
      stat_frames <= frames_q[stat_sel];
      stat_errs   <= errs_q[stat_sel];
    end
  end
`endif

endmodule

// File: tb/tb_uart_rx_sched.sv
// Directed bench for uart_rx_sched (NUM_CH=4, FIFO_DEPTH=8, REARM_CYCLES=4).
// Expected bytes are queued when their rx_done is driven and popped by a
// monitor whenever the stream handshakes. Inputs are driven and outputs
// checked 1 time unit after the rising edge; the monitor samples on the
// falling edge.
module tb_uart_rx_sched;
  localparam int NUM_CH = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NUM_CH-1:0] cfg_ch_en, ovr_clr, rx_en, rx_done, rx_err, ovr;
  logic [8*NUM_CH-1:0] rx_data;
  logic              fifo_full;
`ifdef UART_RX_SCHED_STATS_EN
  logic [1:0]        stat_sel;
  logic [7:0]        stat_frames, stat_errs;
`endif

  uart_rx_sched_if #(.NUM_CH(NUM_CH)) m_if ();

  uart_rx_sched #(.NUM_CH(NUM_CH), .FIFO_DEPTH(8), .REARM_CYCLES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_ch_en (cfg_ch_en),
    .ovr_clr   (ovr_clr),
    .rx_en     (rx_en),
    .rx_data   (rx_data),
    .rx_done   (rx_done),
    .rx_err    (rx_err),
    .m_bus     (m_if.master),
    .ovr       (ovr),
    .fifo_full (fifo_full)
`ifdef UART_RX_SCHED_STATS_EN
    ,
    .stat_sel    (stat_sel),
    .stat_frames (stat_frames),
    .stat_errs   (stat_errs)
`endif
  );

  always #5 clk = ~clk;

  int         checks   = 0;
  int         failures = 0;
  logic [9:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every accepted byte must be the oldest expected one.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && m_if.m_valid === 1'b1 && m_if.m_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_byte", {22'd0, m_if.m_ch, m_if.m_data}, 32'hFFFF_FFFF);
      end else begin
        automatic logic [9:0] e = exp_q.pop_front();
        check("sb_byte", {22'd0, m_if.m_ch, m_if.m_data}, {22'd0, e});
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_q.delete();
  endtask

  // One rx_done pulse; the byte is queued as expected output when asked.
  task automatic send(input logic [1:0] ch, input logic [7:0] d, input bit expect_out);
    rx_data[8*ch +: 8] = d;
    rx_done[ch]        = 1'b1;
    if (expect_out) exp_q.push_back({ch, d});
    tick();
    rx_done = '0;
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check(tag, exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    cfg_ch_en   = '0;
    ovr_clr     = '0;
    rx_done     = '0;
    rx_err      = '0;
    rx_data     = '0;
    m_if.m_ready = 1'b0;
`ifdef UART_RX_SCHED_STATS_EN
    stat_sel    = '0;
`endif
    rst_n = 1'b0;
    tick(2);
    check("rst_rx_en", rx_en, 0);
    check("rst_m_valid", m_if.m_valid, 0);
    check("rst_m_data", m_if.m_data, 0);
    check("rst_m_ch", m_if.m_ch, 0);
    check("rst_ovr", ovr, 0);
    check("rst_fifo_full", fifo_full, 0);
    rst_n = 1'b1;

    // 1: single byte latency
    cfg_ch_en = 4'b0001;
    tick();
    check("t1_rx_en", rx_en, 4'b0001);
    send(2'd0, 8'hA5, 1'b0);
    check("t1_valid_e0", m_if.m_valid, 0);
    tick();
    check("t1_valid_e1", m_if.m_valid, 1);
    check("t1_data", m_if.m_data, 8'hA5);
    check("t1_ch", m_if.m_ch, 0);
    exp_q.push_back({2'd0, 8'hA5});
    m_if.m_ready = 1'b1;
    tick();
    check("t1_popped", m_if.m_valid, 0);
    check("t1_data_hold", m_if.m_data, 8'hA5);

    // 2: round-robin order from reset, then pointer continuation
    reset_pulse();
    cfg_ch_en = 4'b1111;
    tick();
    rx_data = 32'h1312_1110;
    rx_done = 4'b1111;
    for (int c = 0; c < 4; c++) exp_q.push_back({c[1:0], 8'h10 + 8'(c)});
    tick();
    rx_done = '0;
    wait_drain("t2_drain_a", 20);
    rx_data = 32'h0022_0020;
    rx_done = 4'b0101;
    exp_q.push_back({2'd0, 8'h20});
    exp_q.push_back({2'd2, 8'h22});
    tick();
    rx_done = '0;
    wait_drain("t2_drain_b", 20);
    tick(2);
    check("t2_idle", m_if.m_valid, 0);

    // 3: framing error rearm on ch1, done during REARM ignored
    rx_err[1] = 1'b1;
    tick();
    rx_err = '0;
    check("t3_rx_en_rearm", rx_en, 4'b1101);
    send(2'd1, 8'hEE, 1'b0);
    check("t3_low_1", rx_en[1], 0);
    tick();
    check("t3_low_2", rx_en[1], 0);
    tick();
    check("t3_low_3", rx_en[1], 0);
    tick();
    check("t3_rearmed", rx_en[1], 1);
    tick(3);
    check("t3_dropped", m_if.m_valid, 0);
    check("t3_no_ovr", ovr, 0);

    // 4: back-pressure, full FIFO, held slot, overrun, drain, clear
    reset_pulse();
    m_if.m_ready = 1'b0;
    cfg_ch_en = 4'b0001;
    tick();
    for (int k = 0; k < 10; k++) begin
      send(2'd0, 8'h40 + 8'(k), k < 9);
      tick(2);
    end
    check("t4_full", fifo_full, 1);
    check("t4_ovr", ovr, 4'b0001);
    check("t4_head", m_if.m_data, 8'h40);
    m_if.m_ready = 1'b1;
    wait_drain("t4_drain", 40);
    check("t4_ovr_sticky", ovr, 4'b0001);
    ovr_clr = 4'b0001;
    tick();
    ovr_clr = '0;
    check("t4_ovr_clr", ovr, 0);
    check("t4_not_full", fifo_full, 0);

    // 5: asynchronous reset with 5 bytes queued
    reset_pulse();
    m_if.m_ready = 1'b0;
    cfg_ch_en = 4'b0001;
    tick();
    for (int k = 0; k < 5; k++) begin
      send(2'd0, 8'h60 + 8'(k), 1'b0);
      tick(2);
    end
    check("t5_valid_before", m_if.m_valid, 1);
    #3 rst_n = 1'b0;
    #1;
    check("t5_async_valid", m_if.m_valid, 0);
    check("t5_async_rx_en", rx_en, 0);
    check("t5_async_ovr", ovr, 0);
    check("t5_async_full", fifo_full, 0);
    tick();
    rst_n = 1'b1;
    m_if.m_ready = 1'b1;
    tick();
    check("t5_rx_en_back", rx_en, 4'b0001);
    check("t5_lost", m_if.m_valid, 0);

`ifdef UART_RX_SCHED_STATS_EN
    // 6: saturating statistics on ch2
    reset_pulse();
    cfg_ch_en = 4'b0100;
    m_if.m_ready = 1'b1;
    tick();
    for (int k = 0; k < 300; k++) begin
      send(2'd2, 8'(k), 1'b1);
      tick(2);
    end
    wait_drain("t6_drain", 40);
    for (int e = 0; e < 2; e++) begin
      rx_err[2] = 1'b1;
      tick();
      rx_err = '0;
      tick(6);
    end
    stat_sel = 2'd2;
    tick(2);
    check("t6_frames", stat_frames, 255);
    check("t6_errs", stat_errs, 2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
